// File: rtl/tower_accumulator.sv
// Per-tower Et/E accumulator: clears the tower memory, accumulates saturating
// deposits with a forwarded read-modify-write, then streams qualifying towers in index order.
module tower_accumulator #(
  parameter int ETA_W = 5,
  parameter int PHI_W = 5,
  parameter int VAL_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   hit_valid,
  output logic                   hit_ready,
  input  logic [ETA_W-1:0]       hit_eta,
  input  logic [PHI_W-1:0]       hit_phi,
  input  logic [VAL_W-1:0]       hit_et,
  input  logic [VAL_W-1:0]       hit_e,
  input  logic                   evt_end,
  input  logic [VAL_W-1:0]       et_thresh,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ETA_W-1:0]       out_eta,
  output logic [PHI_W-1:0]       out_phi,
  output logic [VAL_W-1:0]       out_et,
  output logic [VAL_W-1:0]       out_e,
  output logic                   done,
  output logic [ETA_W+PHI_W:0]   tower_count
);

  localparam int IDX_W      = ETA_W + PHI_W;
  localparam int NUM_TOWERS = 1 << IDX_W;

  typedef enum logic [2:0] {
    S_CLEAR = 3'd0,
    S_ACCUM = 3'd1,
    S_FLUSH = 3'd2,
    S_SCAN  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  function automatic logic [VAL_W-1:0] sat_add(input logic [VAL_W-1:0] a, input logic [VAL_W-1:0] b);
    logic [VAL_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[VAL_W] ? {VAL_W{1'b1}} : s[VAL_W-1:0];
  endfunction

  state_t r_state;
  state_t w_state_nxt;

  logic [2*VAL_W-1:0] r_mem [NUM_TOWERS];

  logic [IDX_W-1:0]   r_idx;
  logic [IDX_W:0]     r_count;
  logic               r_p_valid;
  logic [IDX_W-1:0]   r_p_idx;
  logic [VAL_W-1:0]   r_p_et, r_p_e, r_old_et, r_old_e;
  logic               r_out_valid, r_done;
  logic [ETA_W-1:0]   r_out_eta;
  logic [PHI_W-1:0]   r_out_phi;
  logic [VAL_W-1:0]   r_out_et, r_out_e;
  logic [IDX_W:0]     r_tower_count;

  logic [IDX_W-1:0]   w_hit_idx, w_idx_inc;
  logic [IDX_W:0]     w_count_inc;
  logic [2*VAL_W-1:0] w_rd;
  logic [VAL_W-1:0]   w_rd_et, w_sum_et, w_sum_e;
  logic               w_last, w_qual, w_hit_acc, w_hs, w_scan_step;

  assign w_hit_idx   = {hit_eta, hit_phi};
  assign w_idx_inc   = r_idx + {{(IDX_W-1){1'b0}}, 1'b1};
  assign w_count_inc = r_count + {{IDX_W{1'b0}}, 1'b1};
  assign w_last      = (r_idx == {IDX_W{1'b1}});
  assign w_rd        = r_mem[r_idx];
  assign w_rd_et     = w_rd[2*VAL_W-1:VAL_W];
  assign w_qual      = (w_rd_et >= et_thresh) && (w_rd_et != {VAL_W{1'b0}});
  assign w_hit_acc   = hit_valid && (r_state == S_ACCUM);
  assign w_sum_et    = sat_add(r_old_et, r_p_et);
  assign w_sum_e     = sat_add(r_old_e, r_p_e);
  assign w_hs        = r_out_valid && out_ready;
  // A tower step ends on a handshake, or at once when the tower does not qualify.
  assign w_scan_step = w_hs || (!r_out_valid && !w_qual);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_CLEAR: if (w_last) w_state_nxt = S_ACCUM; else w_state_nxt = S_CLEAR;
      S_ACCUM: if (evt_end) w_state_nxt = S_FLUSH; else w_state_nxt = S_ACCUM;
      S_FLUSH: w_state_nxt = S_SCAN;
      S_SCAN:  if (w_scan_step && w_last) w_state_nxt = S_DONE; else w_state_nxt = S_SCAN;
      S_DONE:  w_state_nxt = S_CLEAR;
      default: w_state_nxt = S_CLEAR;
    endcase
  end

  // Tower memory has no reset; CLEAR re-zeroes it after every reset and event.
  always_ff @(posedge clk) begin
    if (r_state == S_CLEAR) begin
      r_mem[r_idx] <= {(2*VAL_W){1'b0}};
    end else if (r_p_valid) begin
      r_mem[r_p_idx] <= {w_sum_et, w_sum_e};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_p_valid <= 1'b0;
      r_p_idx   <= {IDX_W{1'b0}};
      r_p_et    <= {VAL_W{1'b0}};
      r_p_e     <= {VAL_W{1'b0}};
      r_old_et  <= {VAL_W{1'b0}};
      r_old_e   <= {VAL_W{1'b0}};
    end else begin
      r_p_valid <= w_hit_acc;
      if (w_hit_acc) begin
        r_p_idx <= w_hit_idx;
        r_p_et  <= hit_et;
        r_p_e   <= hit_e;
        // Forward the sum still being written so back-to-back hits see it.
        if (r_p_valid && (r_p_idx == w_hit_idx)) begin
          r_old_et <= w_sum_et;
          r_old_e  <= w_sum_e;
        end else begin
          r_old_et <= r_mem[w_hit_idx][2*VAL_W-1:VAL_W];
          r_old_e  <= r_mem[w_hit_idx][VAL_W-1:0];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx         <= {IDX_W{1'b0}};
      r_count       <= {(IDX_W+1){1'b0}};
      r_out_valid   <= 1'b0;
      r_out_eta     <= {ETA_W{1'b0}};
      r_out_phi     <= {PHI_W{1'b0}};
      r_out_et      <= {VAL_W{1'b0}};
      r_out_e       <= {VAL_W{1'b0}};
      r_done        <= 1'b0;
      r_tower_count <= {(IDX_W+1){1'b0}};
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_CLEAR: r_idx <= w_idx_inc;
        S_FLUSH: begin
          r_idx   <= {IDX_W{1'b0}};
          r_count <= {(IDX_W+1){1'b0}};
        end
        S_SCAN: begin
          if (w_hs) begin
            r_out_valid <= 1'b0;
            r_count     <= w_count_inc;
          end else if (!r_out_valid && w_qual) begin
            r_out_valid <= 1'b1;
            r_out_eta   <= r_idx[IDX_W-1:PHI_W];
            r_out_phi   <= r_idx[PHI_W-1:0];
            r_out_et    <= w_rd_et;
            r_out_e     <= w_rd[VAL_W-1:0];
          end
          if (w_scan_step) begin
            r_idx <= w_idx_inc;
            if (w_last) begin
              r_done        <= 1'b1;
              r_tower_count <= w_hs ? w_count_inc : r_count;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign hit_ready   = (r_state == S_ACCUM);
  assign out_valid   = r_out_valid;
  assign out_eta     = r_out_eta;
  assign out_phi     = r_out_phi;
  assign out_et      = r_out_et;
  assign out_e       = r_out_e;
  assign done        = r_done;
  assign tower_count = r_tower_count;

endmodule

// File: tb/tb_tower_accumulator.sv
// Self-checking bench for tower_accumulator: directed and random events checked
// against a per-tower array model with saturating sums and an expected beat queue.
module tb_tower_accumulator;
  localparam int NT = 1024;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0, hit_valid = 1'b0, hit_ready, evt_end = 1'b0;
  logic [4:0]  hit_eta = 5'd0, hit_phi = 5'd0, out_eta, out_phi;
  logic [7:0]  hit_et = 8'd0, hit_e = 8'd0, et_thresh = 8'd0, out_et, out_e;
  logic        out_valid, out_ready = 1'b0, done;
  logic [10:0] tower_count;

  int errors = 0;
  int checks = 0;
  int m_et[NT];
  int m_e[NT];
  logic [25:0] exp_q[$];

  tower_accumulator dut (
    .clk(clk), .rst_n(rst_n), .hit_valid(hit_valid), .hit_ready(hit_ready),
    .hit_eta(hit_eta), .hit_phi(hit_phi), .hit_et(hit_et), .hit_e(hit_e),
    .evt_end(evt_end), .et_thresh(et_thresh), .out_valid(out_valid),
    .out_ready(out_ready), .out_eta(out_eta), .out_phi(out_phi),
    .out_et(out_et), .out_e(out_e), .done(done), .tower_count(tower_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NT; i++) begin
      m_et[i] = 0;
      m_e[i]  = 0;
    end
  endtask

  task automatic hit(input int eta, input int phi, input int et, input int e, input bit last);
    int idx;
    @(negedge clk);
    check("hit_ready_accum", {31'd0, hit_ready}, 32'd1);
    hit_valid = 1'b1;
    hit_eta   = eta[4:0];
    hit_phi   = phi[4:0];
    hit_et    = et[7:0];
    hit_e     = e[7:0];
    evt_end   = last;
    idx = eta * 32 + phi;
    m_et[idx] = (m_et[idx] + et > 255) ? 255 : m_et[idx] + et;
    m_e[idx]  = (m_e[idx] + e > 255) ? 255 : m_e[idx] + e;
  endtask

  task automatic idle(input bit last);
    @(negedge clk);
    hit_valid = 1'b0;
    evt_end   = last;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (hit_ready !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("wait_hit_ready", {31'd0, hit_ready}, 32'd1);
  endtask

  // Drains one event's scan; stall_beat selects a beat held off for 10 cycles.
  task automatic run_scan(input int thr, input int stall_beat, input bit rand_ready);
    int exp_n, got, stall;
    bit prev_valid, prev_hs, seen_done;
    logic [25:0] held, cur;
    exp_q.delete();
    for (int i = 0; i < NT; i++) begin
      if (m_et[i] != 0 && m_et[i] >= thr) begin
        logic [9:0] ix;
        ix = i[9:0];
        exp_q.push_back({ix, m_et[i][7:0], m_e[i][7:0]});
      end
    end
    exp_n = exp_q.size();
    got = 0; stall = 0; prev_valid = 0; prev_hs = 0; seen_done = 0; held = '0;
    for (int cyc = 0; cyc < 6000 && !seen_done; cyc++) begin
      @(negedge clk);
      hit_valid = 1'b0;
      evt_end   = 1'b0;
      cur = {out_eta, out_phi, out_et, out_e};
      if (prev_valid && !prev_hs) begin
        check("valid_held", {31'd0, out_valid}, 32'd1);
        check("data_stable", {6'd0, cur}, {6'd0, held});
      end else if (out_valid) begin
        if (exp_q.size() == 0) check("beat_count", got + 1, exp_n);
        else check("beat", {6'd0, cur}, {6'd0, exp_q.pop_front()});
        held = cur;
        if (got == stall_beat) stall = 10;
      end
      if (stall > 0) begin
        out_ready = 1'b0;
        stall--;
      end else begin
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      prev_hs = out_valid && out_ready;
      if (prev_hs) got++;
      prev_valid = out_valid;
      if (done === 1'b1) begin
        seen_done = 1;
        check("done_out_valid", {31'd0, out_valid}, 32'd0);
        check("tower_count", {21'd0, tower_count}, exp_n);
        check("beats_delivered", got, exp_n);
      end
    end
    check("done_seen", {31'd0, seen_done}, 32'd1);
    @(negedge clk);
    check("done_pulse", {31'd0, done}, 32'd0);
    check("tower_count_held", {21'd0, tower_count}, exp_n);
    out_ready = 1'b0;
  endtask

  initial begin
    int n, thr;
    bit ov_seen;
    clear_model();
    // Reset state and CLEAR duration.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hit_ready", {31'd0, hit_ready}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_tower_count", {21'd0, tower_count}, 32'd0);
    check("rst_out_data", {6'd0, out_eta, out_phi, out_et, out_e}, 32'd0);
    rst_n = 1'b1;
    n = 0; ov_seen = 0;
    while (hit_ready !== 1'b1 && n < 3000) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      if (out_valid !== 1'b0) ov_seen = 1;
    end
    check("clear_cycles", n, 1024);
    check("clear_out_valid", {31'd0, ov_seen}, 32'd0);

    // Back-to-back hits to one tower, evt_end on the second.
    et_thresh = 8'd1;
    hit(3, 4, 10, 20, 1'b0);
    hit(3, 4, 5, 7, 1'b1);
    check("model_sum", m_et[3*32+4] * 256 + m_e[3*32+4], 15 * 256 + 27);
    run_scan(1, -1, 1'b0);

    // Saturation.
    clear_model(); wait_ready();
    hit(0, 0, 200, 250, 1'b0);
    hit(0, 0, 100, 10, 1'b1);
    run_scan(1, -1, 1'b0);

    // Threshold boundary and index order.
    clear_model(); wait_ready();
    et_thresh = 8'd5;
    hit(1, 0, 4, 1, 1'b0);
    hit(0, 7, 5, 2, 1'b0);
    hit(2, 2, 9, 3, 1'b0);
    idle(1'b1);
    run_scan(5, -1, 1'b1);

    // Consumer stall mid-scan.
    clear_model(); wait_ready();
    et_thresh = 8'd1;
    hit(0, 3, 7, 7, 1'b0);
    idle(1'b0);
    hit(9, 9, 40, 50, 1'b0);
    hit(31, 31, 1, 1, 1'b1);
    run_scan(1, 1, 1'b0);

    // evt_end alone.
    clear_model(); wait_ready();
    idle(1'b1);
    run_scan(1, -1, 1'b0);

    // Random events with tower collisions, gaps and random thresholds.
    for (int ev = 0; ev < 3; ev++) begin
      clear_model(); wait_ready();
      thr = (ev == 0) ? 0 : $urandom_range(1, 120);
      et_thresh = thr[7:0];
      for (int k = 0; k < 60; k++) begin
        if ($urandom_range(0, 3) == 0) idle(1'b0);
        hit($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255),
            $urandom_range(0, 255), k == 59);
      end
      run_scan(thr, 2, 1'b1);
    end

    // Full-scale event: every tower qualifies.
    clear_model(); wait_ready();
    et_thresh = 8'd1;
    for (int i = 0; i < NT; i++) hit(i / 32, i % 32, 1 + (i % 200), i % 256, i == NT - 1);
    run_scan(1, -1, 1'b0);

    // Reset mid-scan, then a fresh event shows no stale energy.
    clear_model(); wait_ready();
    hit(5, 5, 90, 90, 1'b0);
    hit(6, 6, 80, 80, 1'b1);
    idle(1'b0);
    out_ready = 1'b0;
    n = 0;
    while (out_valid !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("mid_scan_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_scan_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_scan_hit_ready", {31'd0, hit_ready}, 32'd0);
    check("rst_scan_tower_count", {21'd0, tower_count}, 32'd0);
    rst_n = 1'b1;
    clear_model(); wait_ready();
    hit(7, 1, 3, 4, 1'b1);
    run_scan(1, -1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
